// File: rtl/calc_sequencer.sv
// Two-digit BCD calculator: latches operands on start, checks, computes iteratively, converts to BCD.
// Latency: add/sub 17, mul/div 23, error 2 cycles from accept to done; start is ignored while busy.
module calc_sequencer (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic [17:0] SW,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] result_bcd,
  output logic        neg,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {IDLE, CHECK, COMPUTE, CONVERT, DONE} state_t;

  state_t      state;
  logic [17:0] sw_q;
  logic [6:0]  a_bin, b_bin, mplier;
  logic [13:0] work, mcand;
  logic [7:0]  rem;
  logic [3:0]  cnt;
  logic [15:0] bcd, bcd_adj;
  logic        neg_w;
  logic [3:0]  a_t, a_o, b_t, b_o;
  logic [1:0]  op;
  logic [6:0]  a_val, b_val;
  logic [7:0]  div_shift, div_diff;

  assign a_t = sw_q[17:14];
  assign a_o = sw_q[13:10];
  assign b_t = sw_q[9:6];
  assign b_o = sw_q[5:2];
  assign op  = sw_q[1:0];
  assign a_val = {3'd0, a_t} * 7'd10 + {3'd0, a_o};
  assign b_val = {3'd0, b_t} * 7'd10 + {3'd0, b_o};

  // Restoring division step: shift next dividend bit into the partial remainder.
  assign div_shift = {rem[6:0], work[6]};
  assign div_diff  = div_shift - {1'b0, b_bin};

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_bcd <= 16'h0000;
      neg        <= 1'b0;
      status     <= 2'd0;
      sw_q       <= '0;
      a_bin      <= '0;
      b_bin      <= '0;
      mplier     <= '0;
      work       <= '0;
      mcand      <= '0;
      rem        <= '0;
      cnt        <= '0;
      bcd        <= '0;
      neg_w      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sw_q  <= SW;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (a_t > 4'd9 || a_o > 4'd9 || b_t > 4'd9 || b_o > 4'd9) begin
            status     <= 2'd1;
            result_bcd <= 16'h0000;
            neg        <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else if (op == 2'd3 && b_t == 4'd0 && b_o == 4'd0) begin
            status     <= 2'd2;
            result_bcd <= 16'h0000;
            neg        <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            a_bin  <= a_val;
            b_bin  <= b_val;
            mcand  <= {7'd0, a_val};
            mplier <= b_val;
            work   <= (op == 2'd3) ? {7'd0, a_val} : 14'd0;
            rem    <= '0;
            neg_w  <= 1'b0;
            bcd    <= '0;
            cnt    <= '0;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          case (op)
            2'd0: begin
              work  <= {7'd0, a_bin} + {7'd0, b_bin};
              state <= CONVERT;
            end
            2'd1: begin
              if (a_bin >= b_bin) begin
                work <= {7'd0, a_bin - b_bin};
              end else begin
                work  <= {7'd0, b_bin - a_bin};
                neg_w <= 1'b1;
              end
              state <= CONVERT;
            end
            2'd2: begin
              if (mplier[0]) work <= work + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            default: begin
              if (div_shift >= {1'b0, b_bin}) begin
                rem       <= div_diff;
                work[6:0] <= {work[5:0], 1'b1};
              end else begin
                rem       <= div_shift;
                work[6:0] <= {work[5:0], 1'b0};
              end
            end
          endcase
          if (op[1]) begin
            if (cnt == 4'd6) begin
              cnt   <= '0;
              state <= CONVERT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        CONVERT: begin
          bcd  <= {bcd_adj[14:0], work[13]};
          work <= work << 1;
          if (cnt == 4'd13) begin
            result_bcd <= {bcd_adj[14:0], work[13]};
            neg        <= neg_w;
            status     <= 2'd0;
            done       <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL declare its ports as follows (clock and reset first):
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous reset, active-high.
- SW  in  18  operands and operation. SW[17:14] A tens, SW[13:10] A ones, SW[9:6] B tens, SW[5:2] B ones (all BCD). SW[1:0] op: 0 add, 1 sub, 2 mul, 3 div.
- start  in  1  single-cycle request pulse, already debounced.
- busy  out  1  high from the cycle after start is accepted until the cycle DONE is entered.
- done  out  1  high for exactly one cycle when a result is valid.
- result_bcd  out  16  four BCD digits of the result, [15:12] most significant; held between operations.
- neg  out  1  result of a subtraction is negative; result_bcd holds the magnitude.
- status  out  2  0 OK, 1 invalid digit, 2 divide by zero, 3 reserved (never driven).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 States SHALL be IDLE, CHECK, COMPUTE, CONVERT and DONE.
REQ-004 In IDLE, start=1 SHALL latch SW into internal operand and op registers and move the FSM to CHECK. The rest of the block SHALL never look at SW again during that operation.
REQ-005 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-006 CHECK, one cycle:
- Any digit >9: status=1, go to DONE.
- Otherwise, op=3 with B==0: status=2, go to DONE.
- Otherwise: form 7-bit binary A=tens*10+ones and B likewise, go to COMPUTE.
REQ-007 Invalid digit SHALL take priority over divide by zero.
REQ-008 COMPUTE SHALL take 1 cycle for add/sub and exactly 7 cycles for mul/div. Mul is iterative shift-add over the 7 bits of B. Div is restoring division, 7 iterations, quotient only, remainder discarded.
REQ-009 The working result register SHALL be 14 bits wide. Maximum values: sum 198, product 9801.
REQ-010 Sub with A<B SHALL produce B-A and set neg=1. neg SHALL be 0 for every other op and result.
REQ-011 CONVERT SHALL run the 14-bit value through iterative double-dabble: 14 cycles, one shift per cycle, add-3 on any nibble ≥5 before the shift.
REQ-012 DONE, one cycle:
- done=1, busy=0.
- result_bcd, neg and status updated so they are visible in that same cycle.
- Next state IDLE.
REQ-013 On any error status, result_bcd SHALL be 16'h0000 and neg SHALL be 0.
REQ-014 Latency from the clock edge that accepts start to the first cycle with done=1:
- add/sub: 17 cycles.
- mul/div: 23 cycles.
- error: 2 cycles.
REQ-015 start=1 in the DONE cycle SHALL be ignored. start=1 in the first IDLE cycle after DONE SHALL be accepted.
REQ-016 result_bcd, neg and status SHALL change only on entry to DONE or on reset.

Reset
REQ-017 RST=1 at a rising edge SHALL force:
- State IDLE.
- busy=0, done=0, result_bcd=16'h0000, neg=0, status=0.
- All working registers cleared.
REQ-018 RST SHALL take priority over start on the same edge.
REQ-019 RST mid-operation SHALL abort the operation with no done pulse.

Verification
REQ-020 A bench SHALL cover the following directed scenarios:
- SW A=12, B=34, op=0, start -> done at cycle 17, result_bcd=16'h0046, neg=0, status=0.
- A=05, B=20, op=1 -> result_bcd=16'h0015, neg=1, status=0; then A=99, B=99, op=2 -> done at cycle 23, result_bcd=16'h9801.
- A=45, B=00, op=3 -> done at cycle 2, status=2, result_bcd=0; A=1A (ones=4'hA), B=00, op=3 -> status=1.
- A=99, B=07, op=3 -> result_bcd=16'h0014. start pulses at cycles 3 and 10 -> ignored, exactly one done pulse.
- Start a mul, assert RST at cycle 5 -> busy=0 next cycle, no done, outputs zero; a new add then completes normally.
- Change SW every cycle after start -> result reflects the values latched at start.
